muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 27 ++
 rtl/muldiv_ctrl_add_sub32.sv | 12 +
 rtl/muldiv_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide controller.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned PROD_W       = 2 * DATA_W;
    localparam int unsigned ITER_DEFAULT = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Quotient reported for a divide by zero
    localparam logic [DATA_W-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Two's complement negation of one data word
    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_add_sub32.sv
// 32-bit adder/subtractor with carry-out; the single arithmetic unit of the datapath.
module add_sub32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        sub,
    output logic [31:0] s,
    output logic        cout
);
    // sub=1 computes x - y; cout=1 then means no borrow (x >= y)
    assign {cout, s} = 33'(x) + 33'(y ^ {32{sub}}) + 33'(sub);

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add multiplier / restoring divider controller.
// Build option: define MULDIV_SIGNED_EN to honour sgn (signed operands);
// without it every operation is unsigned and no sign-correction logic exists.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic              sgn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_zero
);

    localparam int unsigned      CNT_W    = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t             state, state_d;
    logic               busy_d, done_d;
    logic               accept, b_zero;
    logic               op_q;
    logic [DATA_W-1:0]  a_q, b_q, acc_hi, acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  prep_a, prep_b, fix_hi, fix_lo;
    logic [DATA_W-1:0]  add_x, add_y, add_s;
    logic               add_cout, is_div, div_ok;

    assign accept = start && (state == IDLE || state == DONE);
    assign b_zero = (b_q == '0);
    assign is_div = (op_q == OP_DIV);

    // State register with registered busy/done derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = PREP;
            PREP:    state_d = (is_div && b_zero) ? DONE : CALC;
            CALC:    if (cnt == CNT_LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = start ? PREP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode for the cycle after the edge
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == PREP || state_d == CALC || state_d == FIX) busy_d = 1'b1;
        if (state_d == DONE) done_d = 1'b1;
    end

    // Operand selection for the shared adder: divide trial-subtract or multiply accumulate
    assign add_x  = is_div ? {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]} : acc_hi;
    assign add_y  = (is_div || acc_lo[0]) ? b_q : '0;
    assign div_ok = acc_hi[DATA_W-1] | add_cout;

    add_sub32 u_add_sub (
        .x    (add_x),
        .y    (add_y),
        .sub  (is_div),
        .s    (add_s),
        .cout (add_cout)
    );

`ifdef MULDIV_SIGNED_EN
    logic                sgn_q, neg_res, neg_rem, sa, sb;
    logic [PROD_W-1:0]   prod_neg;

    assign sa       = sgn_q & a_q[DATA_W-1];
    assign sb       = sgn_q & b_q[DATA_W-1];
    assign prep_a   = sa ? neg32(a_q) : a_q;
    assign prep_b   = sb ? neg32(b_q) : b_q;
    assign prod_neg = ~{acc_hi, acc_lo} + PROD_W'(1);

    // Capture signedness on accept and latch result signs while preparing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            sgn_q <= sgn;
        end else if (state == PREP) begin
            neg_res <= sa ^ sb;
            neg_rem <= sa;
        end
    end

    // Sign correction of the magnitude result
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            if (neg_res) {fix_hi, fix_lo} = prod_neg;
        end else begin
            if (neg_res) fix_lo = neg32(acc_lo);
            if (neg_rem) fix_hi = neg32(acc_hi);
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign prep_a     = a_q;
    assign prep_b     = b_q;
    assign fix_hi     = acc_hi;
    assign fix_lo     = acc_lo;
`endif

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_q     <= op;
                        a_q      <= a;
                        b_q      <= b;
                        div_zero <= 1'b0;
                    end
                end
                PREP: begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= prep_a;
                    b_q    <= prep_b;
                    if (is_div && b_zero) begin
                        hi       <= a_q;
                        lo       <= DIV_ZERO_Q;
                        div_zero <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc_hi <= div_ok ? add_s : add_x;
                        acc_lo <= {acc_lo[DATA_W-2:0], div_ok};
                    end else begin
                        acc_hi <= {add_cout, add_s[DATA_W-1:1]};
                        acc_lo <= {add_s[0], acc_lo[DATA_W-1:1]};
                    end
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MAX_WAIT = 200;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, op, sgn;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, n_done, first;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request after edge 0, then scramble the inputs after edge 1
    task automatic start_op(input logic o, input logic s, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk); #1;
        start = 1'b1; op = o; sgn = s; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; sgn = ~s; a = ~av; b = ~bv;
        check("busy_prep", 64'(busy), 64'(1));
    endtask

    // Count edges until done; optionally pulse start while busy
    task automatic wait_done(input bit poke, output int l);
        l = 1;
        while (done !== 1'b1 && l < MAX_WAIT) begin
            @(posedge clk); #1;
            l++;
            if (poke && l == 10) begin
                start = 1'b1; op = OP_MUL; a = 32'h5; b = 32'h1;
            end
            if (poke && l == 11) start = 1'b0;
        end
    endtask

    task automatic expect_res(input string tag, input int l, input int exp_l,
                              input logic [31:0] eh, input logic [31:0] el, input logic ez);
        check({tag, "_lat"}, 64'(l), 64'(exp_l));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dz"}, 64'(div_zero), 64'(ez));
        @(posedge clk); #1;
        check({tag, "_after"}, 64'({busy, done}), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_ctl", 64'({busy, done, div_zero}), 64'(0));
        check("rst_res", {hi, lo}, 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        start_op(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, lat);
        expect_res("mul_max", lat, 35, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        start_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat);
        expect_res("div_neg7", lat, 35,
                   SIGNED_BUILD ? 32'hFFFF_FFFF : 32'h1,
                   SIGNED_BUILD ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0);

        start_op(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat);
        expect_res("div_u7", lat, 35, 32'h1, 32'h7FFF_FFFC, 1'b0);

        start_op(OP_DIV, 1'b0, 32'h1234, 32'h0);
        wait_done(1'b0, lat);
        expect_res("div_zero", lat, 2, 32'h1234, 32'hFFFF_FFFF, 1'b1);

        start_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat);
        expect_res("div_ovf", lat, 35,
                   SIGNED_BUILD ? 32'h0 : 32'h8000_0000,
                   SIGNED_BUILD ? 32'h8000_0000 : 32'h0, 1'b0);

        start_op(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_done(1'b0, lat);
        expect_res("mul_neg3", lat, 35,
                   SIGNED_BUILD ? 32'hFFFF_FFFF : 32'h4, 32'hFFFF_FFF1, 1'b0);

        start_op(OP_DIV, 1'b0, 32'd100, 32'd7);
        wait_done(1'b1, lat);
        expect_res("div_poke", lat, 35, 32'd2, 32'd14, 1'b0);

        // Reset in the middle of a divide
        start_op(OP_DIV, 1'b0, 32'h1000, 32'h3);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", 64'({busy, done, div_zero}), 64'(0));
        check("rst_mid_res", {hi, lo}, 64'(0));
        n_done = 0;
        repeat (3) begin @(posedge clk); #1; if (done) n_done++; end
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
        check("rst_no_done", 64'(n_done), 64'(0));
        start_op(OP_MUL, 1'b0, 32'd6, 32'd7);
        wait_done(1'b0, lat);
        expect_res("mul_6x7", lat, 35, 32'd0, 32'd42, 1'b0);

        // start held high: rearm from DONE, results hold until the next DONE
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; sgn = 1'b0; a = 32'd3; b = 32'd5;
        n_done = 0;
        first  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first == 0) begin
                    first = c;
                    check("hold_first_res", {hi, lo}, 64'd15);
                    a = 32'd7;
                end
            end
            if (c == 36) check("hold_rearm_busy", 64'(busy), 64'(1));
        end
        check("hold_pulses", 64'(n_done), 64'(1));
        check("hold_first_lat", 64'(first), 64'(35));
        check("hold_keep", {hi, lo}, 64'd15);
        start = 1'b0;
        lat = 40;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        expect_res("hold_second", lat, 70, 32'd0, 32'd35, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
